timer_run_controller: RTL and testbench



---
 rtl/timer_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/timer_run_controller.sv | 200 ++++++++++++++++++++
 tb/tb_timer_run_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, mode constants and counter sizing for the timer run controller
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, level debouncer and one-cycle press pulse for an active-low button
module btn_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          sample;

  // Internal levels are active-high: 1 means pressed.
  assign sample = ~sync_q[1];

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sample != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sample;
        press_d = sample;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/timer_run_controller.sv
// rtl/timer_run_controller.sv - run/mode sequencer issuing load/decrement strobes, alarm and blink for the countdown datapath
module timer_run_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int ALARM_SEC    = 10,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       btn_start_n,
  input  logic       btn_set_n,
  input  logic [1:0] mode_sel,
  input  logic       cnt_zero,
  output logic       load_en,
  output logic [1:0] preset_sel,
  output logic       dec_en,
  output logic       running,
  output logic       alarm,
  output logic       blink,
  output logic [2:0] state
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam int BW = cnt_width(BLINK_DIV);
  localparam int AW = cnt_width(ALARM_SEC);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_SEC - 1);

  logic start_press, set_press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .btn_n (btn_start_n),
    .press (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_set_db (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .btn_n (btn_set_n),
    .press (set_press)
  );

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_next;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [1:0]    preset_sel_q, preset_sel_d;
  logic          load_en_q, load_en_d;
  logic          dec_en_q, dec_en_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          blink_q, blink_d;
  logic          tick_term;

  assign tick_term = (tick_q == TICK_MAX);
  assign tick_next = tick_term ? '0 : tick_q + TW'(1);

  function automatic logic is_blink_state(input state_t s);
    return (s == ST_PAUSED) || (s == ST_EXPIRED);
  endfunction

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    alarm_cnt_d  = '0;
    preset_sel_d = preset_sel_q;
    load_en_d    = 1'b0;
    dec_en_d     = 1'b0;
    blink_d      = 1'b0;
    blink_cnt_d  = '0;

    // Set is checked first in every state so it wins over a same-cycle start.
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (set_press) begin
          preset_sel_d = mode_sel;
          load_en_d    = 1'b1;
          state_d      = ST_LOADED;
        end
      end
      ST_LOADED: begin
        tick_d = '0;
        if (set_press) begin
          preset_sel_d = mode_sel;
          load_en_d    = 1'b1;
        end else if (start_press) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (set_press) begin
          preset_sel_d = mode_sel;
          load_en_d    = 1'b1;
          tick_d       = '0;
          state_d      = ST_LOADED;
        end else if (start_press) begin
          state_d = ST_PAUSED;
        end else begin
          tick_d = tick_next;
          if (tick_term) begin
            if (cnt_zero) state_d = ST_EXPIRED;
            else          dec_en_d = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (set_press) begin
          preset_sel_d = mode_sel;
          load_en_d    = 1'b1;
          tick_d       = '0;
          state_d      = ST_LOADED;
        end else if (start_press) begin
          state_d = ST_RUNNING;
        end
      end
      ST_EXPIRED: begin
        alarm_cnt_d = alarm_cnt_q;
        if (set_press) begin
          preset_sel_d = mode_sel;
          load_en_d    = 1'b1;
          tick_d       = '0;
          state_d      = ST_LOADED;
        end else if (start_press) begin
          tick_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tick_d = tick_next;
          if (tick_term) begin
            if (alarm_cnt_q == ALARM_MAX) begin
              alarm_cnt_d = '0;
              state_d     = ST_IDLE;
            end else begin
              alarm_cnt_d = alarm_cnt_q + AW'(1);
            end
          end
        end
      end
      default: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Entering a blinking state always starts blanked with a fresh half-period.
    if (is_blink_state(state_d)) begin
      if (state_d != state_q) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    running_d = (state_d == ST_RUNNING);
    alarm_d   = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      blink_cnt_q  <= '0;
      alarm_cnt_q  <= '0;
      preset_sel_q <= 2'd0;
      load_en_q    <= 1'b0;
      dec_en_q     <= 1'b0;
      running_q    <= 1'b0;
      alarm_q      <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      blink_cnt_q  <= blink_cnt_d;
      alarm_cnt_q  <= alarm_cnt_d;
      preset_sel_q <= preset_sel_d;
      load_en_q    <= load_en_d;
      dec_en_q     <= dec_en_d;
      running_q    <= running_d;
      alarm_q      <= alarm_d;
      blink_q      <= blink_d;
    end
  end

  assign load_en    = load_en_q;
  assign preset_sel = preset_sel_q;
  assign dec_en     = dec_en_q;
  assign running    = running_q;
  assign alarm      = alarm_q;
  assign blink      = blink_q;
  assign state      = state_q;

endmodule

// File: tb/tb_timer_run_controller.sv
// tb/tb_timer_run_controller.sv - scoreboard bench for timer_run_controller with scaled-down timing parameters
module tb_timer_run_controller;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start_n = 1'b1;
  logic       btn_set_n = 1'b1;
  logic [1:0] mode_sel = 2'd0;
  logic       cnt_zero = 1'b0;
  logic       load_en, dec_en, running, alarm, blink;
  logic [1:0] preset_sel;
  logic [2:0] state;

  timer_run_controller #(
    .TICK_DIV(10), .DEBOUNCE_CYC(4), .ALARM_SEC(3), .BLINK_DIV(5)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .btn_start_n(btn_start_n), .btn_set_n(btn_set_n),
    .mode_sel(mode_sel), .cnt_zero(cnt_zero), .load_en(load_en), .preset_sel(preset_sel),
    .dec_en(dec_en), .running(running), .alarm(alarm), .blink(blink), .state(state)
  );

  always #5 clk_50M = ~clk_50M;

  // Expected event: {state, load_en, dec_en, preset_sel, running, alarm, blink}; gap 0 = untimed.
  typedef struct packed {
    logic [9:0] v;
    logic [7:0] gap;
  } exp_t;

  exp_t       q[$];
  int         errs = 0;
  int         chks = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [2:0] prev_state = 3'd0;
  logic       prev_blink = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    chks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic ld, input logic dc, input logic [1:0] ps,
                      input logic rn, input logic al, input logic bl, input int gap);
    exp_t e;
    e.v   = {st, ld, dc, ps, rn, al, bl};
    e.gap = 8'(gap);
    q.push_back(e);
  endtask

  task automatic monitor();
    logic [9:0] obs;
    exp_t       e;
    forever begin
      @(negedge clk_50M);
      cyc++;
      obs = {state, load_en, dec_en, preset_sel, running, alarm, blink};
      if (state !== prev_state || load_en || dec_en || blink !== prev_blink) begin
        if (q.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_event: actual=%0h required=none (cycle %0d)", obs, cyc);
        end else begin
          e = q.pop_front();
          check("event", 32'(obs), 32'(e.v));
          if (e.gap != 8'd0) check("event_gap", cyc - last_cyc, 32'(e.gap));
        end
        last_cyc = cyc;
      end
      prev_state = state;
      prev_blink = blink;
    end
  endtask

  task automatic press(input bit st, input bit set, input int len);
    btn_start_n = ~st;
    btn_set_n   = ~set;
    repeat (len) @(negedge clk_50M);
    btn_start_n = 1'b1;
    btn_set_n   = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (state !== st && n < budget);
    check("wait_state", 32'(state), 32'(st));
  endtask

  task automatic wait_dec(input int budget);
    int n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (dec_en !== 1'b1 && n < budget);
    check("wait_dec", 32'(dec_en), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk_50M);
      n++;
    end
    check("drain", q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    check("reset_outputs", 32'({state, load_en, dec_en, preset_sel, running, alarm, blink}), 32'd0);

    // Set from IDLE latches mode 2; a 3-cycle glitch and a bare mode change do nothing.
    mode_sel = 2'd2;
    push(3'd1, 1, 0, 2'd2, 0, 0, 0, 0);
    press(0, 1, 6);
    drain(20);
    idle_cycles(10);
    mode_sel = 2'd1;
    press(0, 1, 3);
    idle_cycles(12);
    check("glitch_preset", 32'(preset_sel), 32'd2);
    check("glitch_state", 32'(state), 32'd1);

    // Run, three decrements, then zero count expires and alarm times out.
    push(3'd2, 0, 0, 2'd2, 1, 0, 0, 0);
    repeat (3) push(3'd2, 0, 1, 2'd2, 1, 0, 0, 10);
    push(3'd4, 0, 0, 2'd2, 0, 1, 1, 10);
    for (int i = 0; i < 5; i++) push(3'd4, 0, 0, 2'd2, 0, 1, (i % 2 == 1), 5);
    push(3'd0, 0, 0, 2'd2, 0, 0, 0, 5);
    press(1, 0, 6);
    repeat (3) wait_dec(20);
    cnt_zero = 1'b1;
    drain(60);
    cnt_zero = 1'b0;
    idle_cycles(10);

    // Pause at tick 6, blink while paused, resume continues the frozen tick.
    push(3'd1, 1, 0, 2'd1, 0, 0, 0, 0);
    press(0, 1, 6);
    drain(20);
    idle_cycles(10);
    push(3'd2, 0, 0, 2'd1, 1, 0, 0, 0);
    push(3'd2, 0, 1, 2'd1, 1, 0, 0, 10);
    push(3'd3, 0, 0, 2'd1, 0, 0, 1, 7);
    push(3'd3, 0, 0, 2'd1, 0, 0, 0, 5);
    push(3'd3, 0, 0, 2'd1, 0, 0, 1, 5);
    push(3'd2, 0, 0, 2'd1, 1, 0, 0, 5);
    push(3'd2, 0, 1, 2'd1, 1, 0, 0, 4);
    press(1, 0, 6);
    wait_dec(20);
    press(1, 0, 6);
    wait_state(3'd3, 10);
    idle_cycles(8);
    press(1, 0, 6);
    wait_dec(20);

    // Expire again and acknowledge with start.
    push(3'd4, 0, 0, 2'd1, 0, 1, 1, 10);
    push(3'd4, 0, 0, 2'd1, 0, 1, 0, 5);
    push(3'd0, 0, 0, 2'd1, 0, 0, 0, 3);
    cnt_zero = 1'b1;
    wait_state(3'd4, 20);
    @(negedge clk_50M);
    press(1, 0, 6);
    drain(20);
    cnt_zero = 1'b0;
    idle_cycles(10);

    // Simultaneous start+set while running: set wins, relatches mode 0.
    mode_sel = 2'd3;
    push(3'd1, 1, 0, 2'd3, 0, 0, 0, 0);
    press(0, 1, 6);
    drain(20);
    idle_cycles(10);
    push(3'd2, 0, 0, 2'd3, 1, 0, 0, 0);
    push(3'd2, 0, 1, 2'd3, 1, 0, 0, 10);
    push(3'd1, 1, 0, 2'd0, 0, 0, 0, 7);
    press(1, 0, 6);
    mode_sel = 2'd0;
    wait_dec(20);
    press(1, 1, 6);
    drain(20);
    idle_cycles(15);
    check("simul_state", 32'(state), 32'd1);

    // Asynchronous reset mid-run, then a full set/start sequence is required.
    push(3'd2, 0, 0, 2'd0, 1, 0, 0, 0);
    press(1, 0, 6);
    wait_state(3'd2, 10);
    idle_cycles(3);
    push(3'd0, 0, 0, 2'd0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({state, load_en, dec_en, preset_sel, running, alarm, blink}), 32'd0);
    @(negedge clk_50M);
    #2 rst_n = 1'b1;
    @(negedge clk_50M);
    press(1, 0, 6);
    idle_cycles(15);
    check("start_ignored_idle", 32'(state), 32'd0);
    mode_sel = 2'd2;
    push(3'd1, 1, 0, 2'd2, 0, 0, 0, 0);
    press(0, 1, 6);
    drain(20);
    idle_cycles(10);
    push(3'd2, 0, 0, 2'd2, 1, 0, 0, 0);
    push(3'd2, 0, 1, 2'd2, 1, 0, 0, 10);
    press(1, 0, 6);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
